// File: rtl/chan_err_inj.sv
// chan_err_inj: binary-symmetric channel model with LFSR-driven, guard-spaced single-bit error injection
module chan_err_inj #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned GUARD = 8,
    parameter int unsigned CT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      enc_sym_i,
    input  logic            sym_valid_i,
    input  logic            err_en_i,
    input  logic [7:0]      err_rate_i,
    input  logic            force_err_i,
    output logic [1:0]      chan_sym_o,
    output logic            sym_valid_o,
    output logic [1:0]      err_inj,
    output logic [CT_W-1:0] bad_bit_ct,
    output logic            holdoff_o
);

    typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} state_t;

    localparam logic [7:0] GUARD_CT = 8'(GUARD);

    state_t          state_q, state_d;
    logic [7:0]      guard_ct_q, guard_ct_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [1:0]      chan_sym_q, chan_sym_d;
    logic [1:0]      err_inj_q, err_inj_d;
    logic            sym_valid_q, sym_valid_d;
    logic [CT_W-1:0] bad_bit_ct_q, bad_bit_ct_d;
    logic            hit;
    logic            inject;
    logic [1:0]      mask;

    // Draw against the pre-advance LFSR value; the LFSR steps once per valid symbol only
    always_comb begin
        lfsr_d = sym_valid_i ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
        hit    = (lfsr_q[7:0] < err_rate_i) | force_err_i;
        inject = sym_valid_i & err_en_i & (state_q == ARMED) & hit;
        mask   = inject ? (lfsr_q[8] ? 2'b10 : 2'b01) : 2'b00;
    end

    // Injection FSM: disable exits every cycle, everything else advances on valid symbols
    always_comb begin
        state_d    = state_q;
        guard_ct_d = guard_ct_q;
        if (!err_en_i) begin
            state_d    = IDLE;
            guard_ct_d = '0;
        end else if (sym_valid_i) begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED: begin
                    if (hit) begin
                        state_d    = HOLDOFF;
                        guard_ct_d = GUARD_CT;
                    end
                end
                HOLDOFF: begin
                    guard_ct_d = (guard_ct_q == 8'd0) ? 8'd0 : guard_ct_q - 8'd1;
                    state_d    = (guard_ct_q <= 8'd1) ? ARMED : HOLDOFF;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output datapath: XOR the mask in, hold the last symbol on idle cycles, saturate the count
    always_comb begin
        sym_valid_d  = sym_valid_i;
        err_inj_d    = mask;
        chan_sym_d   = sym_valid_i ? (enc_sym_i ^ mask) : chan_sym_q;
        bad_bit_ct_d = (inject && (bad_bit_ct_q != '1)) ? bad_bit_ct_q + CT_W'(1) : bad_bit_ct_q;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            guard_ct_q   <= '0;
            lfsr_q       <= SEED;
            chan_sym_q   <= '0;
            err_inj_q    <= '0;
            sym_valid_q  <= 1'b0;
            bad_bit_ct_q <= '0;
        end else begin
            state_q      <= state_d;
            guard_ct_q   <= guard_ct_d;
            lfsr_q       <= lfsr_d;
            chan_sym_q   <= chan_sym_d;
            err_inj_q    <= err_inj_d;
            sym_valid_q  <= sym_valid_d;
            bad_bit_ct_q <= bad_bit_ct_d;
        end
    end

    assign chan_sym_o  = chan_sym_q;
    assign sym_valid_o = sym_valid_q;
    assign err_inj     = err_inj_q;
    assign bad_bit_ct  = bad_bit_ct_q;
    assign holdoff_o   = (state_q == HOLDOFF);

endmodule

// File: tb/tb_chan_err_inj.sv
// tb_chan_err_inj: randomized self-checking bench for chan_err_inj against a symbol-level reference model
module tb_chan_err_inj;

    localparam int GUARD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  enc_sym_i = '0;
    logic        sym_valid_i = 1'b0;
    logic        err_en_i = 1'b0;
    logic [7:0]  err_rate_i = '0;
    logic        force_err_i = 1'b0;
    logic [1:0]  chan_sym_o, err_inj;
    logic        sym_valid_o, holdoff_o;
    logic [15:0] bad_bit_ct;
    logic [1:0]  chan4, inj4;
    logic        valid4, hold4;
    logic [3:0]  ct4;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_lfsr;
    bit          m_active;
    int          m_guard;
    int          m_ct;
    logic [1:0]  m_chan;
    int          sym_idx;
    int          last_inj;
    int          inj_q[$];

    chan_err_inj #(.GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .enc_sym_i(enc_sym_i), .sym_valid_i(sym_valid_i),
        .err_en_i(err_en_i), .err_rate_i(err_rate_i), .force_err_i(force_err_i),
        .chan_sym_o(chan_sym_o), .sym_valid_o(sym_valid_o), .err_inj(err_inj),
        .bad_bit_ct(bad_bit_ct), .holdoff_o(holdoff_o)
    );

    chan_err_inj #(.GUARD(GUARD), .CT_W(4)) dut4 (
        .clk(clk), .rst(rst), .enc_sym_i(enc_sym_i), .sym_valid_i(sym_valid_i),
        .err_en_i(err_en_i), .err_rate_i(err_rate_i), .force_err_i(force_err_i),
        .chan_sym_o(chan4), .sym_valid_o(valid4), .err_inj(inj4),
        .bad_bit_ct(ct4), .holdoff_o(hold4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int sat(input int v, input int top);
        return (v > top) ? top : v;
    endfunction

    task automatic model_reset();
        m_lfsr   = 16'hACE1;
        m_active = 0;
        m_guard  = 0;
        m_ct     = 0;
        m_chan   = '0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_chan", chan_sym_o, 0);
        chk("rst_valid", sym_valid_o, 0);
        chk("rst_inj", err_inj, 0);
        chk("rst_ct", bad_bit_ct, 0);
        chk("rst_ct4", ct4, 0);
        chk("rst_hold", holdoff_o, 0);
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic cyc(input bit v, input bit en, input bit frc, input logic [7:0] rate, input logic [1:0] sym);
        logic [1:0]  m;
        logic [15:0] l;
        sym_valid_i = v;
        err_en_i    = en;
        force_err_i = frc;
        err_rate_i  = rate;
        enc_sym_i   = sym;
        chk("holdoff", holdoff_o, m_guard > 0);
        chk("holdoff4", hold4, m_guard > 0);
        m = 2'b00;
        if (v) begin
            l = m_lfsr;
            m_lfsr = lfsr_next(l);
            sym_idx++;
            if (en) begin
                if (!m_active) m_active = 1;
                else if (m_guard > 0) m_guard--;
                else if ((l[7:0] < rate) || frc) begin
                    m = l[8] ? 2'b10 : 2'b01;
                    m_guard = GUARD;
                    m_ct++;
                end
            end
            m_chan = sym ^ m;
        end
        if (!en) begin
            m_active = 0;
            m_guard  = 0;
        end
        @(posedge clk);
        #1;
        chk("valid", sym_valid_o, v);
        chk("err_inj", err_inj, m);
        chk("chan", chan_sym_o, m_chan);
        chk("ct", bad_bit_ct, sat(m_ct, 65535));
        chk("lfsr", dut.lfsr_q, m_lfsr);
        chk("chan4", chan4, m_chan);
        chk("inj4", inj4, m);
        chk("valid4", valid4, v);
        chk("ct4", ct4, sat(m_ct, 15));
    endtask

    initial begin
        model_reset();
        do_reset();

        // Transparency with injection disabled
        for (int i = 0; i < 64; i++) cyc(1, 0, $urandom_range(0, 1), 8'($urandom), 2'($urandom));

        // Forced injection, guard spacing
        sym_idx = 0;
        inj_q.delete();
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 1, 8'd0, 2'($urandom));
            if (err_inj != 2'b00) begin
                inj_q.push_back(sym_idx);
                chk("onehot", $countones(err_inj), 1);
            end
        end
        chk("inj_n", inj_q.size(), 5);
        foreach (inj_q[i]) chk("inj_at", inj_q[i], 2 + 9 * i);
        chk("ct_forced", bad_bit_ct, 5);

        // High-rate draws: spacing and exact count
        last_inj = -1;
        for (int i = 0; i < 1000; i++) begin
            cyc(1, 1, 0, 8'd255, 2'($urandom));
            if (err_inj != 2'b00) begin
                if (last_inj >= 0) chk("spacing", (sym_idx - last_inj) > GUARD, 1);
                last_inj = sym_idx;
            end
        end
        chk("ct_rate", bad_bit_ct, m_ct);
        chk("ct4_sat", ct4, 15);

        // Gapped valid with force held
        for (int i = 0; i < 60; i++) cyc(i % 2 == 0, 1, 1, 8'd0, 2'($urandom));
        for (int i = 0; i < 40; i++) cyc($urandom_range(0, 2) != 0, 1, $urandom_range(0, 1), 8'($urandom), 2'($urandom));

        // Disable three symbols into the guard interval
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 8'd0, 2'($urandom));
        chk("mid_hold", holdoff_o, 1);
        cyc(0, 0, 1, 8'd0, 2'b00);
        chk("dis_hold", holdoff_o, 0);
        chk("dis_guard", dut.guard_ct_q, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 1, 8'd0, 2'($urandom));

        // Asynchronous reset mid-stream, then restart from the seed
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1, 1, $urandom_range(0, 1), 8'($urandom), 2'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/chan_err_inj.md
# chan_err_inj

Binary-symmetric channel model with controlled, decodable error injection. Sits between the rate-1/2 convolutional encoder and the Viterbi decoder inside the tx/rx chain. Takes 2-bit encoded symbols and forwards them with at most one flipped bit per symbol. An LFSR draw against a programmable rate decides which symbols are corrupted, and a guard interval between injections keeps the error pattern within the decoder's correction capability. It exports per-symbol error flags and a saturating corrupted-bit count to the scoreboard.

## Interface
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- GUARD, 8, minimum number of valid symbols forwarded clean after any injection (1..255).
- CT_W, 16, width of bad_bit_ct.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- enc_sym_i  input  2  encoder output symbol {g1,g0}.
- sym_valid_i  input  1  enc_sym_i is valid this cycle.
- err_en_i  input  1  enables injection; when low, the channel is transparent.
- err_rate_i  input  8  per-symbol injection probability = err_rate_i/256.
- force_err_i  input  1  injects on the current valid symbol regardless of the rate draw; guard still applies.
- chan_sym_o  output  2  channel output symbol to the decoder.
- sym_valid_o  output  1  chan_sym_o is valid.
- err_inj  output  2  bit mask flipped on the current chan_sym_o (one-hot or zero).
- bad_bit_ct  output  CT_W  total bits flipped since reset; saturates at all-ones.
- holdoff_o  output  1  high while the guard interval is active.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (shift right, XOR mask 16'hB400 when LSB=1). Advances exactly once per cycle with sym_valid_i=1, independent of state and err_en_i. Holds otherwise.
- Draw uses the pre-advance value L. hit = (L[7:0] < err_rate_i) | force_err_i. Bit select: L[8]=0 flips bit 0, L[8]=1 flips bit 1.
- FSM, evaluated only on cycles with sym_valid_i=1, except the err_en_i exit, which is evaluated every cycle:
  - IDLE: no injection. Go to ARMED when err_en_i=1.
  - ARMED: if hit, inject, load guard_ct=GUARD and go to HOLDOFF. Otherwise forward clean.
  - HOLDOFF: forward clean and decrement guard_ct. On the valid symbol where guard_ct reaches 0, return to ARMED; injection is possible on the next valid symbol, not the same one.
  - From any state, err_en_i=0 forces IDLE and clears guard_ct on the next clock edge.
- Injection: chan_sym_o = enc_sym_i ^ mask and err_inj = mask, where mask = 2'b01 or 2'b10. Without injection, mask = 2'b00.
- bad_bit_ct increments by 1 per injected symbol and holds at 2^CT_W-1.
- With err_rate_i=0 and force_err_i=0, the channel never injects. With err_rate_i=255, it injects on 255/256 of ARMED draws.
- force_err_i during HOLDOFF or IDLE is ignored. It is not queued.

## Timing
- One-cycle registered latency: a symbol valid at edge n appears on chan_sym_o/sym_valid_o/err_inj after edge n.
- When sym_valid_i=0: sym_valid_o=0, err_inj=0, chan_sym_o holds its last value, and the LFSR, FSM and guard_ct hold.
- Back-to-back valid symbols are supported every cycle with no stall and no backpressure.
- holdoff_o is registered with state and is high for exactly GUARD valid symbols following an injected symbol.
- Reset values: chan_sym_o=0, sym_valid_o=0, err_inj=0, bad_bit_ct=0, holdoff_o=0, state=IDLE, guard_ct=0, LFSR=SEED.
- Reset asserted mid-stream: all outputs drop to reset values immediately (asynchronously). The first valid symbol after release uses L=SEED and sees state IDLE, so it cannot be injected even if err_en_i=1.
- err_en_i and hit on the same cycle while in IDLE: the transition to ARMED takes effect first, and that symbol is forwarded clean.

## Test plan
- Reset then transparency: err_en_i=0, stream 64 random symbols -> chan_sym_o equals input delayed 1 cycle, err_inj=0 throughout, bad_bit_ct=0.
- Forced injection and guard: err_en_i=1, err_rate_i=0, force_err_i held high, GUARD=8, 40 valid symbols -> injections on symbols 2, 11, 20, 29, 38 (the first is clean because of the IDLE->ARMED step), each with exactly one err_inj bit set, bad_bit_ct=5, holdoff_o high for 8 symbols after each injection.
- Rate extreme: err_rate_i=255, 1000 valid symbols -> no two injections closer than GUARD+1 symbols apart, and bad_bit_ct matches the reference-model LFSR prediction exactly.
- Gapped valid: sym_valid_i toggling 1-0-1-0 with force_err_i=1 -> the guard counts valid symbols only, the LFSR sequence is identical to the ungapped run, and sym_valid_o=0 cycles carry err_inj=0.
- Mid-holdoff disable and async reset: drop err_en_i 3 symbols into HOLDOFF -> IDLE next edge and guard_ct=0. Re-enable, then assert rst between clock edges -> outputs clear immediately, and the LFSR restarts at 16'hACE1.
- Saturation: CT_W=4, force injections -> bad_bit_ct stops at 15 and stays at 15.
